// File: rtl/demux_pkg.sv
// Shared types and default sizes for the 1-to-N stream demultiplexer.
package demux_pkg;
    localparam int DEMUX_DW   = 4;
    localparam int DEMUX_NCH  = 4;
    localparam int DEMUX_CNTW = 8;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;
    typedef logic [DEMUX_DW-1:0] beat_t;
endpackage

// File: rtl/demux_out_slot.sv
// One output channel: single-entry holding register with valid/ready drain
// and a wrapping delivered-beat counter.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DW   = DEMUX_DW,
    parameter int CNTW = DEMUX_CNTW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            load_i,
    input  logic [DW-1:0]   data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    output logic [CNTW-1:0] cnt_o
);
    slot_state_t     state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            drain;

    // Handshakes presented during a flush cycle are discarded, not counted.
    assign drain = (state_q == SLOT_FULL) && ready_i && !flush;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= SLOT_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)       state_d = SLOT_EMPTY;
        else if (load_i) state_d = SLOT_FULL;
        else if (drain)  state_d = SLOT_EMPTY;
    end

    always_comb begin
        valid_o = (state_q == SLOT_FULL);
        data_o  = data_q;
        cnt_o   = cnt_q;
    end

    always_comb begin
        data_d = load_i ? data_i : data_q;
        cnt_d  = drain ? cnt_q + CNTW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/demux_stream_1to4.sv
// Registered 1-to-NCH stream demux: steers each beat to the slot named by
// in_sel; a stalled channel only blocks beats addressed to it.
module demux_stream_1to4
    import demux_pkg::*;
#(
    parameter int DW   = DEMUX_DW,
    parameter int NCH  = DEMUX_NCH,
    parameter int SELW = $clog2(NCH),
    parameter int CNTW = DEMUX_CNTW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic [DW-1:0]     in_data,
    input  logic [SELW-1:0]   in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*CNTW-1:0] xfer_cnt
);
    logic           accept;
    logic [NCH-1:0] load;

    // Readiness looks only at the addressed slot, never at in_valid.
    assign in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign load[n] = accept && (in_sel == SELW'(n));

        demux_out_slot #(.DW(DW), .CNTW(CNTW)) u_slot (
            .clk     (clk),
            .rstn    (rstn),
            .flush   (flush),
            .load_i  (load[n]),
            .data_i  (in_data),
            .ready_i (out_ready[n]),
            .valid_o (out_valid[n]),
            .data_o  (out_data[n*DW +: DW]),
            .cnt_o   (xfer_cnt[n*CNTW +: CNTW])
        );
    end
endmodule

// File: tb/tb_demux_stream_1to4.sv
// Directed bench for demux_stream_1to4 with hand-computed expectations.
module tb_demux_stream_1to4;
    import demux_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready;
    beat_t       in_data;
    logic [1:0]  in_sel;
    logic [15:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic [31:0] xfer_cnt;
    int          passed = 0;
    int          total  = 0;

    demux_stream_1to4 dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_data(in_data),
        .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs and samples change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ecnt;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        in_data = 4'hF; out_ready = 4'b0000;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_cnt",   xfer_cnt,       32'h0);
        in_valid = 1'b0; rstn = 1'b1;
        step();
        chk("rst_nocapture", 32'(out_valid), 32'h0);

        // single beat to ch2
        out_ready = 4'b1111; in_sel = 2'd2; in_data = 4'hA; in_valid = 1'b1;
        #1 chk("single_ready", 32'(in_ready), 32'h1);
        step(); in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'h4);
        chk("single_data",  32'(out_data[11:8]), 32'hA);
        step();
        chk("single_cnt2",  32'(xfer_cnt[23:16]), 32'h1);
        chk("single_empty", 32'(out_valid), 32'h0);

        // backpressure on ch1
        out_ready = 4'b1101; in_sel = 2'd1; in_data = 4'h3; in_valid = 1'b1;
        step();
        chk("bp_load", 32'(out_data[7:4]), 32'h3);
        in_data = 4'h5;
        #1 chk("bp_stall_ready", 32'(in_ready), 32'h0);
        step();
        chk("bp_hold_data",  32'(out_data[7:4]), 32'h3);
        chk("bp_hold_valid", 32'(out_valid), 32'h2);
        out_ready = 4'b1111;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
        step(); in_valid = 1'b0;
        chk("bp_swap_valid", 32'(out_valid), 32'h2);
        chk("bp_swap_data",  32'(out_data[7:4]), 32'h5);
        chk("bp_cnt1",       32'(xfer_cnt[15:8]), 32'h1);
        step();
        chk("bp_cnt1_b", 32'(xfer_cnt[15:8]), 32'h2);
        chk("bp_empty",  32'(out_valid), 32'h0);

        // independence: ch0 stalled, ch3 still accepts
        out_ready = 4'b0000; in_sel = 2'd0; in_data = 4'h9; in_valid = 1'b1;
        step();
        in_sel = 2'd3; in_data = 4'h7;
        #1 chk("ind_ready3", 32'(in_ready), 32'h1);
        step();
        chk("ind_valid",  32'(out_valid), 32'h9);
        chk("ind_data3",  32'(out_data[15:12]), 32'h7);
        chk("ind_data0",  32'(out_data[3:0]), 32'h9);
        in_sel = 2'd0;
        #1 chk("ind_ready0", 32'(in_ready), 32'h0);

        // flush with ch0/ch2/ch3 full; handshakes in the flush cycle don't count
        in_sel = 2'd2; in_data = 4'hC;
        step();
        chk("fl_pre_valid", 32'(out_valid), 32'hD);
        flush = 1'b1; out_ready = 4'b1111; in_sel = 2'd1; in_data = 4'hE;
        #1 chk("fl_ready", 32'(in_ready), 32'h0);
        step(); flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'h0);
        chk("fl_cnt",   xfer_cnt, 32'h0001_0200);
        chk("fl_data",  32'(out_data), 32'h7C59);

        // 256 back-to-back beats to ch0, counter wraps
        in_sel = 2'd0; in_valid = 1'b1;
        ecnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            in_data = i[3:0];
            #1 chk("wr_ready", 32'(in_ready), 32'h1);
            step();
            chk("wr_valid", 32'(out_valid), 32'h1);
            chk("wr_data",  32'(out_data[3:0]), 32'(i[3:0]));
            chk("wr_cnt",   32'(xfer_cnt[7:0]), 32'(ecnt));
            ecnt = ecnt + 8'd1;
        end
        in_valid = 1'b0;
        step();
        chk("wr_wrap_cnt", 32'(xfer_cnt[7:0]), 32'h0);
        chk("wr_empty",    32'(out_valid), 32'h0);

        // mid-operation reset discards a full slot, overriding flush
        out_ready = 4'b0000; in_sel = 2'd1; in_data = 4'h6; in_valid = 1'b1;
        step();
        chk("mr_loaded", 32'(out_valid), 32'h2);
        rstn = 1'b0; flush = 1'b1;
        step();
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_data",  32'(out_data), 32'h0);
        chk("mr_cnt",   xfer_cnt, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
